// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with a sticky access timeout.
// Build option: define MEM_ARB_FAIR_EN for round-robin arbitration when both requesters are pending.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        ERR    = 2'd3
    } state_t;

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_data_q, last_data_d;
    logic        err_q;

    logic dreq;
    logic in_igrant, in_dgrant;
    logic i_active, d_active;
    logic granted_req;

    assign dreq      = dREN | dWEN;
    assign in_igrant = (state_q == IGRANT);
    assign in_dgrant = (state_q == DGRANT);

    // Strobes follow the live request so an abort drops them in the same cycle.
    assign i_active  = in_igrant & iREN;
    assign d_active  = in_dgrant & dreq;

    assign ram_ren   = i_active | (d_active & ~dWEN);
    assign ram_wen   = d_active & dWEN;
    assign ram_addr  = i_active ? iaddr : (d_active ? daddr : '0);
    assign ram_store = d_active ? dstore : '0;

    assign iwait = iREN & ~(in_igrant & ram_ready);
    assign dwait = dreq & ~(in_dgrant & ram_ready);
    assign iload = in_igrant ? ram_load : '0;
    assign dload = in_dgrant ? ram_load : '0;
    assign err   = err_q;

    assign granted_req = in_igrant ? iREN : dreq;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Round-robin only matters when both are pending and data went last.
                if (dreq && !(FAIR && iREN && last_data_q)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT, DGRANT: begin
                if (!granted_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ram_ready) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    last_data_d = in_dgrant;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_data_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            err_q       <= (state_d == ERR);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and a randomized run against a reference model.
module tb_mem_arbiter;

    localparam int TO = 4;
    localparam int ST_IDLE = 0, ST_I = 1, ST_D = 2, ST_ERR = 3;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic        iwait, dwait, ram_ren, ram_wen, err;
    logic [31:0] iload, dload, ram_addr, ram_store;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .err(err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the RAM, how long the owner has waited, who was served last.
    int m_owner;
    int m_waited;
    bit m_last_data;
    bit g_iwait, g_dwait;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren, dwen;
        logic [31:0] daddr, dstore;
        logic        rdy;
        logic [31:0] load;
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        logic        e_err;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [132:0] dut_outs();
        return {iwait, dwait, ram_ren, ram_wen, ram_addr, ram_store, iload, dload, err};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner     = ST_IDLE;
        m_waited    = 0;
        m_last_data = 1'b0;
    endtask

    task automatic check_model(input string nm);
        bit gi, gd, dq, ai, ad;
        logic [132:0] exp;
        gi = (m_owner == ST_I);
        gd = (m_owner == ST_D);
        dq = dREN | dWEN;
        ai = gi & iREN;
        ad = gd & dq;
        g_iwait = iREN & !(gi & ram_ready);
        g_dwait = dq & !(gd & ram_ready);
        exp = {g_iwait, g_dwait,
               ai | (ad & !dWEN), ad & dWEN,
               ai ? iaddr : (ad ? daddr : 32'h0),
               ad ? dstore : 32'h0,
               gi ? ram_load : 32'h0,
               gd ? ram_load : 32'h0,
               (m_owner == ST_ERR)};
        n_checks++;
        if (dut_outs() !== exp) begin
            n_fail++;
            $display("FAIL %s model: got %h expected %h", nm, dut_outs(), exp);
        end
    endtask

    task automatic model_step();
        bit dq, take_data, still;
        dq = dREN | dWEN;
        case (m_owner)
            ST_IDLE: begin
                take_data = dq;
                if (FAIR && dq && iREN && m_last_data) take_data = 1'b0;
                if (take_data) m_owner = ST_D;
                else if (iREN) m_owner = ST_I;
                m_waited = 0;
            end
            ST_I, ST_D: begin
                still = (m_owner == ST_I) ? iREN : dq;
                if (!still) begin
                    m_owner  = ST_IDLE;
                    m_waited = 0;
                end else if (ram_ready) begin
                    m_last_data = (m_owner == ST_D);
                    m_owner     = ST_IDLE;
                    m_waited    = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TO) m_owner = ST_ERR;
                end
            end
            default: ;
        endcase
    endtask

    task automatic sample_end(input string nm);
        check_model(nm);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic cycle(input string nm);
        @(negedge CLK);
        sample_end(nm);
    endtask

    task automatic zero_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ram_load = 32'h0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        zero_inputs();
        #1;
        model_reset();
        check_model("reset_state");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_ig;
        bit [1:0] r;

        tbl[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        32'h0, 1'b0};
        tbl[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'hDEADBEEF,
                    1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0, 1'b0};
        tbl[4]  = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'hCAFEF00D,
                    1'b0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0, 1'b0};
        tbl[6]  = '{1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h12345678, 32'h0,        32'h0, 1'b0};
        tbl[7]  = '{1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'h12345678, 1'b1, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h12345678, 32'h0,        32'h0, 1'b0};
        tbl[8]  = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0, 1'b0};
        tbl[9]  = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h55AA55AA,
                    1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0,        32'h55AA55AA, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0, 1'b0};
        tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0,        32'h0, 1'b0};
        tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b1, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0,        32'h0, 1'b0};
        tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h408, 32'h0,        1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0, 1'b0};
        tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h408, 32'h0,        1'b1, 32'h0BADF00D,
                    1'b0, 1'b0, 1'b1, 1'b0, 32'h408, 32'h0,        32'h0,        32'h0BADF00D, 1'b0};
        tbl[15] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0, 1'b0};

        // Vector table: instruction reads, write vs fetch collision, read+write together.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [132:0] e;
            iREN = tbl[i].iren;   iaddr = tbl[i].iaddr;
            dREN = tbl[i].dren;   dWEN = tbl[i].dwen;
            daddr = tbl[i].daddr; dstore = tbl[i].dstore;
            ram_ready = tbl[i].rdy; ram_load = tbl[i].load;
            @(negedge CLK);
            e = {tbl[i].e_iwait, tbl[i].e_dwait, tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr,
                 tbl[i].e_store, tbl[i].e_iload, tbl[i].e_dload, tbl[i].e_err};
            n_checks++;
            if (dut_outs() !== e) begin
                n_fail++;
                $display("FAIL tbl[%0d]: got %h expected %h", i, dut_outs(), e);
            end
            sample_end($sformatf("tbl[%0d]", i));
        end

        // Both requesters held with fast RAM: strict starves fetch, fair alternates.
        do_reset();
        iREN = 1'b1; iaddr = 32'h700; dREN = 1'b1; daddr = 32'h800;
        ram_ready = 1'b1; ram_load = 32'h11112222;
        n_ig = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (ram_ren && ram_addr == 32'h700) n_ig++;
            sample_end("contend");
        end
        chk("contend_igrants", 64'(n_ig), FAIR ? 64'd3 : 64'd0);

        // Abort: data drops its request mid-grant, pending fetch follows.
        do_reset();
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600;
        cycle("abort_idle0");
        dREN = 1'b0;
        @(negedge CLK);
        chk("abort_ren_drop", 64'(ram_ren), 64'd0);
        sample_end("abort_drop");
        @(negedge CLK);
        chk("abort_idle_ren", 64'({ram_ren, iwait}), 64'b01);
        sample_end("abort_idle");
        ram_ready = 1'b1; ram_load = 32'h600DF00D;
        @(negedge CLK);
        chk("abort_then_igrant", {31'h0, ram_ren, ram_addr}, {31'h0, 1'b1, 32'h500});
        sample_end("abort_igrant");

        // Timeout: four unanswered grant cycles trap into the sticky error.
        do_reset();
        iREN = 1'b1; iaddr = 32'h40;
        cycle("to_idle");
        for (int i = 0; i < TO; i++) begin
            @(negedge CLK);
            chk("to_grant_ren", 64'({ram_ren, err}), 64'b10);
            sample_end("to_grant");
        end
        @(negedge CLK);
        chk("to_err", 64'({err, ram_ren, ram_wen, iwait}), 64'b1001);
        sample_end("to_err");
        ram_ready = 1'b1;
        @(negedge CLK);
        chk("to_err_sticky", 64'({err, iwait}), 64'b11);
        sample_end("to_sticky");
        ram_ready = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("to_err_cleared", 64'(err), 64'd0);
        model_reset();
        @(posedge CLK); #1 nRST = 1'b1;

        // Asynchronous reset in the middle of a data grant, then counter restarts from zero.
        iREN = 1'b0; dREN = 1'b1; daddr = 32'h900;
        cycle("rst_idle");
        @(negedge CLK);
        chk("rst_pre_ren", 64'(ram_ren), 64'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_async", 64'({ram_ren, ram_wen, err}), 64'd0);
        model_reset();
        check_model("rst_async_model");
        @(posedge CLK); #1 nRST = 1'b1;
        for (int i = 0; i < TO + 2; i++) cycle("rst_recount");
        chk("rst_recount_err", 64'(err), 64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (!iREN || !g_iwait) begin
                iREN = 1'($urandom_range(0, 1)); iaddr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                iREN = 1'b0;
            end
            if (!(dREN | dWEN) || !g_dwait) begin
                r = 2'($urandom_range(0, 3));
                dREN = r[0]; dWEN = r[1]; daddr = $urandom; dstore = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                dREN = 1'b0; dWEN = 1'b0;
            end
            ram_ready = ($urandom_range(0, 2) != 0);
            ram_load = $urandom;
            cycle("rand");
            if (m_owner == ST_ERR && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-ported RAM between the instruction-fetch requester and the data requester of the pipelined core.
- Fetch and memory stages stall on their wait outputs; the arbiter grants one requester at a time, drives the RAM strobes, and reports completion.
- Adds a per-access timeout that traps a hung RAM into a sticky error state.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM port
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles a grant may wait for ram_ready before error (1..2^16-1)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  instruction stall; 0 = iload valid this cycle
- iload  out  DATA_W  instruction data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  data stall; 0 = access completes this cycle
- dload  out  DATA_W  read data
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data
- ram_ready  in  1  RAM completes current access this cycle
- err  out  1  sticky timeout error

Behaviour:
- State register: IDLE, IGRANT, DGRANT, ERR. Reset: state = IDLE, timeout counter = 0, last_grant = instruction, err = 0.
- Requesters hold address, data and request stable until their wait drops.
- IDLE:
  - RAM strobes 0.
  - dREN|dWEN → DGRANT.
  - Else iREN → IGRANT.
  - Else stay.
  - Both pending: data wins (see optional feature).
- IGRANT: ram_ren = 1, ram_wen = 0, ram_addr = iaddr.
- DGRANT: ram_addr = daddr, ram_store = dstore.
  - dWEN → ram_wen = 1, ram_ren = 0.
  - dREN only → ram_ren = 1.
  - dREN and dWEN together: write wins, no read.
- Completion: in the granted state with ram_ready = 1:
  - The granted wait output is 0 that same cycle; iload/dload = ram_load combinationally.
  - Next state IDLE, giving one mandatory turnaround cycle.
  - last_grant updated; counter cleared.
- Wait outputs:
  - iwait = iREN & ~(state==IGRANT & ram_ready)
  - dwait = (dREN|dWEN) & ~(state==DGRANT & ram_ready)
  - With no request, the wait output is 0.
- Abort: granted request deasserted before ram_ready → strobes drop that cycle, next state IDLE, counter cleared, last_grant unchanged.
- Timeout: counter increments each grant cycle without ram_ready. If counter == TIMEOUT-1 and ram_ready = 0 → ERR. ram_ready on the final cycle still completes normally.
- ERR:
  - err = 1, strobes 0, iwait = iREN, dwait = dREN|dWEN.
  - Exits only via nRST.
- Outside a grant: iload = dload = 0. ram_addr and ram_store = 0 when not driven.
- nRST asserted mid-access: immediate return to reset values, strobes 0 asynchronously.
- Latency: minimum 1 cycle IDLE plus 1 cycle grant (ram_ready same cycle). A back-to-back access from the same requester costs 2 cycles.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined: in IDLE with both requesters pending, grant the one opposite to last_grant (round-robin). A lone requester is always granted.
- Undefined: strict data priority; instruction is served only when no data request is pending. Fetch starvation is permitted.

Test Plan:
- Instruction read only:
  - Stimulus: iREN = 1, iaddr = 0x100; ram_ready asserted 2nd cycle of IGRANT with ram_load = 0xDEADBEEF.
  - Response: ram_ren = 1 and ram_addr = 0x100 in IGRANT; iwait = 0 and iload = 0xDEADBEEF in the ready cycle; state = IDLE the next cycle.
- Simultaneous requests:
  - Stimulus: iREN = 1 with dWEN = 1, daddr = 0x200, dstore = 0x12345678.
  - Response: write granted first, ram_wen = 1 with that address and data; iwait stays 1.
  - Response, fair build: instruction granted next.
  - Response, strict build with dREN held high: instruction never granted.
- Abort:
  - Stimulus: dREN dropped during DGRANT before ram_ready.
  - Response: ram_ren = 0 in the same cycle; IDLE the next cycle; pending iREN then granted.
- Timeout, TIMEOUT = 4:
  - Stimulus: ram_ready held 0 during IGRANT.
  - Response: err = 1 after 4 grant cycles; strobes 0; err stays 1 when ram_ready later pulses; cleared only by nRST.
- Reset mid-access:
  - Stimulus: nRST asserted asynchronously in DGRANT.
  - Response: strobes 0 and err = 0 immediately; after release, state = IDLE with the counter at 0.
- Read/write both high:
  - Stimulus: dREN = dWEN = 1.
  - Response: ram_wen = 1, ram_ren = 0.
